ula_seq_16: RTL and testbench

ULA_SEQ_16 -- requirements
Module: ula_seq_16

---
 rtl/ula_seq_16.sv | 152 +++++++++++++++
 tb/tb_ula_seq_16.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ula_seq_16.sv
// Sequential W-bit ALU wrapper: issues one 4-bit nibble per cycle to an external
// combinational ALU slice, chaining carry and equality across nibbles.
module ula_seq_16 #(
    parameter int unsigned NIB = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,

    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [4*NIB-1:0]     req_a,
    input  logic [4*NIB-1:0]     req_b,
    input  logic [3:0]           req_s,
    input  logic                 req_m,
    input  logic                 req_cin,

    output logic [3:0]           alu_a,
    output logic [3:0]           alu_b,
    output logic [3:0]           alu_s,
    output logic                 alu_m,
    output logic                 alu_cin,
    input  logic [3:0]           alu_f,
    input  logic                 alu_cout,
    input  logic                 alu_aeqb,

    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [4*NIB-1:0]     rsp_f,
    output logic                 rsp_cout,
    output logic                 rsp_aeqb,
    output logic                 rsp_zero
);

    localparam int unsigned W = 4 * NIB;

    typedef enum logic [1:0] {StIdle, StIssue, StDone} state_e;

    state_e         state_q, state_d;
    logic [2:0]     k_q, k_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [W-1:0]   res_q, res_d;
    logic [3:0]     s_q, s_d;
    logic           m_q, m_d;
    logic           carry_q, carry_d;
    logic           eq_q, eq_d;

    logic           last_slice;
    logic [5:0]     sh;
    logic [W-1:0]   a_sh, b_sh, nib_mask;

    assign last_slice = (k_q == 3'(NIB - 1));
    assign sh         = {k_q, 2'b00};
    assign a_sh       = a_q >> sh;
    assign b_sh       = b_q >> sh;
    assign nib_mask   = W'(4'hF) << sh;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            k_q     <= 3'd0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            s_q     <= 4'd0;
            m_q     <= 1'b0;
            carry_q <= 1'b0;
            eq_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            s_q     <= s_d;
            m_q     <= m_d;
            carry_q <= carry_d;
            eq_q    <= eq_d;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        s_d     = s_q;
        m_d     = m_q;
        carry_d = carry_q;
        eq_d    = eq_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    a_d     = req_a;
                    b_d     = req_b;
                    s_d     = req_s;
                    m_d     = req_m;
                    carry_d = req_cin;
                    eq_d    = 1'b1;
                    k_d     = 3'd0;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                res_d   = (res_q & ~nib_mask) | (W'(alu_f) << sh);
                carry_d = alu_cout;
                eq_d    = eq_q & alu_aeqb;
                if (last_slice) begin
                    state_d = StDone;
                end else begin
                    k_d = k_q + 3'd1;
                end
            end
            StDone: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        alu_a     = 4'd0;
        alu_b     = 4'd0;
        alu_s     = 4'd0;
        alu_m     = 1'b1;
        alu_cin   = 1'b0;
        unique case (state_q)
            StIdle: req_ready = 1'b1;
            StIssue: begin
                alu_a   = a_sh[3:0];
                alu_b   = b_sh[3:0];
                alu_s   = s_q;
                alu_m   = m_q;
                // Logic mode never propagates carry into the slice.
                alu_cin = carry_q & ~m_q;
            end
            StDone: rsp_valid = 1'b1;
            default: ;
        endcase
    end

    assign rsp_f    = res_q;
    assign rsp_cout = carry_q & ~m_q;
    assign rsp_aeqb = eq_q;
    assign rsp_zero = (state_q == StDone) && (res_q == '0);

endmodule

// File: tb/tb_ula_seq_16.sv
// Bench for ula_seq_16 (NIB=4) paired with a behavioural 74181-style 4-bit slice;
// results are checked against a full-width arithmetic reference.
module tb_ula_seq_16;

    localparam int NIB = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_ready;
    logic [15:0] req_a = '0, req_b = '0;
    logic [3:0]  req_s = '0;
    logic        req_m = 1'b0, req_cin = 1'b0;
    logic [3:0]  alu_a, alu_b, alu_s, alu_f;
    logic        alu_m, alu_cin, alu_cout, alu_aeqb;
    logic        rsp_valid, rsp_ready = 1'b0;
    logic [15:0] rsp_f;
    logic        rsp_cout, rsp_aeqb, rsp_zero;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ula_seq_16 #(.NIB(NIB)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_s(req_s), .req_m(req_m), .req_cin(req_cin),
        .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_m(alu_m), .alu_cin(alu_cin),
        .alu_f(alu_f), .alu_cout(alu_cout), .alu_aeqb(alu_aeqb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_f(rsp_f), .rsp_cout(rsp_cout), .rsp_aeqb(rsp_aeqb), .rsp_zero(rsp_zero)
    );

    // Arithmetic functions as F = X + Y + cin with bitwise X, Y ("minus 1" is plus all-ones).
    function automatic logic [31:0] fn_xy(input logic [15:0] a, b, input logic [3:0] s);
        logic [15:0] x, y;
        case (s)
            4'd0:    begin x = a;      y = 16'h0;   end
            4'd1:    begin x = a | b;  y = 16'h0;   end
            4'd2:    begin x = a | ~b; y = 16'h0;   end
            4'd3:    begin x = 16'h0;  y = 16'hFFFF; end
            4'd4:    begin x = a;      y = a & ~b;  end
            4'd5:    begin x = a | b;  y = a & ~b;  end
            4'd6:    begin x = a;      y = ~b;      end
            4'd7:    begin x = a & ~b; y = 16'hFFFF; end
            4'd8:    begin x = a;      y = a & b;   end
            4'd9:    begin x = a;      y = b;       end
            4'd10:   begin x = a | ~b; y = a & b;   end
            4'd11:   begin x = a & b;  y = 16'hFFFF; end
            4'd12:   begin x = a;      y = a;       end
            4'd13:   begin x = a | b;  y = a;       end
            4'd14:   begin x = a | ~b; y = a;       end
            default: begin x = a;      y = 16'hFFFF; end
        endcase
        return {x, y};
    endfunction

    // Returns {aeqb, cout, f[15:0]} for an n-bit wide ALU.
    function automatic logic [17:0] alu_model(input logic [15:0] a, b, input logic [3:0] s,
                                              input logic m, cin, input int n);
        logic [16:0] mask, sum;
        logic [15:0] f, x, y;
        logic [31:0] xy;
        logic        cout;
        mask = (17'd1 << n) - 17'd1;
        cout = 1'b0;
        if (m) begin
            case (s)
                4'd0:    f = ~a;
                4'd1:    f = ~(a | b);
                4'd2:    f = ~a & b;
                4'd3:    f = 16'h0;
                4'd4:    f = ~(a & b);
                4'd5:    f = ~b;
                4'd6:    f = a ^ b;
                4'd7:    f = a & ~b;
                4'd8:    f = ~a | b;
                4'd9:    f = ~(a ^ b);
                4'd10:   f = b;
                4'd11:   f = a & b;
                4'd12:   f = 16'hFFFF;
                4'd13:   f = a | ~b;
                4'd14:   f = a | b;
                default: f = a;
            endcase
        end else begin
            xy   = fn_xy(a, b, s);
            x    = xy[31:16];
            y    = xy[15:0];
            sum  = ({1'b0, x} & mask) + ({1'b0, y} & mask) + {16'h0, cin};
            f    = sum[15:0];
            cout = sum[n];
        end
        f = f & mask[15:0];
        return {((a & mask[15:0]) == (b & mask[15:0])), cout, f};
    endfunction

    // Carry into bit 4k of the full-width sum.
    function automatic logic chain_cin(input logic [15:0] a, b, input logic [3:0] s,
                                       input logic cin, input int k);
        logic [31:0] xy;
        logic [16:0] mk, sum;
        if (k == 0) return cin;
        xy  = fn_xy(a, b, s);
        mk  = (17'd1 << (4 * k)) - 17'd1;
        sum = ({1'b0, xy[31:16]} & mk) + ({1'b0, xy[15:0]} & mk) + {16'h0, cin};
        return sum[4*k];
    endfunction

    logic [17:0] slice_r;
    always_comb slice_r = alu_model({12'h0, alu_a}, {12'h0, alu_b}, alu_s, alu_m, alu_cin, 4);
    assign alu_f    = slice_r[3:0];
    assign alu_cout = slice_r[16];
    assign alu_aeqb = slice_r[17];

    // Drives one operation from a negedge, holds rsp_ready low for `hold` DONE cycles, then
    // handshakes; returns to the caller on the negedge after the handshake.
    task automatic run_op(input logic [15:0] a, b, input logic [3:0] s, input logic m, cin,
                          input int hold, output logic [15:0] f, output logic cout, aeqb, zero,
                          output int lat, output logic [7:0] cins, output logic [15:0] alua,
                          output logic stable, output logic idle_ok);
        int n;
        int e;
        req_a = a; req_b = b; req_s = s; req_m = m; req_cin = cin;
        req_valid = 1'b1;
        rsp_ready = 1'b0;
        cins = '0; alua = '0; f = '0; cout = 0; aeqb = 0; zero = 0;
        stable = 1'b1; idle_ok = 1'b1; lat = -1;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            checks++; errors++;
            $display("FAIL accept_timeout: req_ready=%0b required 1", req_ready);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_a = 16'($urandom); req_b = 16'($urandom); req_s = 4'($urandom);
        req_m = 1'($urandom); req_cin = 1'($urandom);
        e = 0;
        @(negedge clk);
        while (!rsp_valid && e < 40) begin
            if (e < 8) cins[e] = alu_cin;
            if (e < NIB) alua[4*e +: 4] = alu_a;
            e++;
            @(negedge clk);
        end
        if (!rsp_valid) begin
            checks++; errors++;
            $display("FAIL rsp_timeout: rsp_valid=%0b required 1", rsp_valid);
            return;
        end
        lat = e + 1;
        f = rsp_f; cout = rsp_cout; aeqb = rsp_aeqb; zero = rsp_zero;
        for (int i = 0; i <= hold; i++) begin
            if (i > 0) @(negedge clk);
            if (!rsp_valid || req_ready || rsp_f !== f || rsp_cout !== cout ||
                rsp_aeqb !== aeqb || rsp_zero !== zero) stable = 1'b0;
            if (alu_a !== 4'd0 || alu_b !== 4'd0 || alu_s !== 4'd0 || alu_m !== 1'b1 ||
                alu_cin !== 1'b0) idle_ok = 1'b0;
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (rsp_valid !== 1'b0 || rsp_f !== 16'h0 || rsp_cout !== 1'b0 || rsp_aeqb !== 1'b0 ||
            rsp_zero !== 1'b0) begin
            errors++;
            $display("FAIL reset_rsp: valid=%0b f=%h cout=%0b aeqb=%0b zero=%0b required all 0",
                     rsp_valid, rsp_f, rsp_cout, rsp_aeqb, rsp_zero);
        end
        checks++;
        if ({alu_a, alu_b, alu_s, alu_m, alu_cin} !== 14'b00000000000010) begin
            errors++;
            $display("FAIL reset_alu: a=%h b=%h s=%h m=%0b cin=%0b required 0,0,0,1,0",
                     alu_a, alu_b, alu_s, alu_m, alu_cin);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: req_ready=%0b rsp_valid=%0b required 1,0",
                     req_ready, rsp_valid);
        end
    endtask

    task automatic test_directed();
        logic [15:0] f, alua;
        logic        cout, aeqb, zero, stable, idle_ok;
        logic [7:0]  cins;
        int          lat;
        run_op(16'h0FFF, 16'h0001, 4'b1001, 1'b0, 1'b0, 0, f, cout, aeqb, zero, lat, cins,
               alua, stable, idle_ok);
        checks++;
        if (f !== 16'h1000 || cout !== 1'b0 || zero !== 1'b0 || aeqb !== 1'b0) begin
            errors++;
            $display("FAIL add_0fff: f=%h cout=%0b zero=%0b aeqb=%0b required 1000,0,0,0",
                     f, cout, zero, aeqb);
        end
        checks++;
        if (lat !== NIB + 1) begin
            errors++;
            $display("FAIL latency: got %0d edges required %0d", lat, NIB + 1);
        end
        run_op(16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b0, 0, f, cout, aeqb, zero, lat, cins,
               alua, stable, idle_ok);
        checks++;
        if (f !== 16'h0000 || cout !== 1'b1 || zero !== 1'b1) begin
            errors++;
            $display("FAIL add_ffff: f=%h cout=%0b zero=%0b required 0000,1,1", f, cout, zero);
        end
        checks++;
        if (cins[3:0] !== 4'b1110) begin
            errors++;
            $display("FAIL cin_chain: k0..k3 bits=%b required 1110 (k3..k0)", cins[3:0]);
        end
        run_op(16'hA5A5, 16'h5A5A, 4'b0110, 1'b1, 1'b1, 0, f, cout, aeqb, zero, lat, cins,
               alua, stable, idle_ok);
        checks++;
        if (f !== 16'hFFFF || cout !== 1'b0 || aeqb !== 1'b0 || cins[3:0] !== 4'b0000) begin
            errors++;
            $display("FAIL xor_logic: f=%h cout=%0b aeqb=%0b cins=%b required ffff,0,0,0000",
                     f, cout, aeqb, cins[3:0]);
        end
        run_op(16'h3C3C, 16'h3C3C, 4'b1111, 1'b1, 1'b0, 0, f, cout, aeqb, zero, lat, cins,
               alua, stable, idle_ok);
        checks++;
        if (f !== 16'h3C3C || aeqb !== 1'b1) begin
            errors++;
            $display("FAIL aeqb_equal: f=%h aeqb=%0b required 3c3c,1", f, aeqb);
        end
        run_op(16'h3C3C, 16'h3C3D, 4'b1111, 1'b1, 1'b0, 0, f, cout, aeqb, zero, lat, cins,
               alua, stable, idle_ok);
        checks++;
        if (f !== 16'h3C3C || aeqb !== 1'b0) begin
            errors++;
            $display("FAIL aeqb_differ: f=%h aeqb=%0b required 3c3c,0", f, aeqb);
        end
    endtask

    task automatic test_random(input int count);
        logic [15:0] a, b, f, alua;
        logic [3:0]  s;
        logic        m, cin, cout, aeqb, zero, stable, idle_ok;
        logic [7:0]  cins, exp_cins;
        logic [17:0] exp;
        int          lat;
        for (int i = 0; i < count; i++) begin
            a = 16'($urandom); b = 16'($urandom); s = 4'($urandom);
            m = 1'($urandom); cin = 1'($urandom);
            if ($urandom_range(0, 5) == 0) b = a;
            run_op(a, b, s, m, cin, $urandom_range(0, 3), f, cout, aeqb, zero, lat, cins,
                   alua, stable, idle_ok);
            exp = alu_model(a, b, s, m, cin, 16);
            exp_cins = '0;
            for (int k = 0; k < NIB; k++) exp_cins[k] = m ? 1'b0 : chain_cin(a, b, s, cin, k);
            checks++;
            if (f !== exp[15:0] || cout !== exp[16] || aeqb !== exp[17] ||
                zero !== (exp[15:0] == 16'h0)) begin
                errors++;
                $display("FAIL rand_result[%0d]: f=%h cout=%0b aeqb=%0b zero=%0b required %h,%0b,%0b,%0b (a=%h b=%h s=%h m=%0b cin=%0b)",
                         i, f, cout, aeqb, zero, exp[15:0], exp[16], exp[17],
                         exp[15:0] == 16'h0, a, b, s, m, cin);
            end
            checks++;
            if (cins !== exp_cins || alua !== a || lat !== NIB + 1) begin
                errors++;
                $display("FAIL rand_issue[%0d]: cins=%b alu_a=%h lat=%0d required %b,%h,%0d",
                         i, cins, alua, lat, exp_cins, a, NIB + 1);
            end
            checks++;
            if (stable !== 1'b1 || idle_ok !== 1'b1) begin
                errors++;
                $display("FAIL rand_hold[%0d]: stable=%0b idle=%0b required 1,1",
                         i, stable, idle_ok);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] a, b, f, alua;
        logic        cout, aeqb, zero, stable, idle_ok;
        logic [7:0]  cins;
        logic [17:0] exp;
        int          lat;
        a = 16'($urandom); b = 16'($urandom);
        run_op(a, b, 4'b1001, 1'b0, 1'b1, 10, f, cout, aeqb, zero, lat, cins, alua, stable,
               idle_ok);
        exp = alu_model(a, b, 4'b1001, 1'b0, 1'b1, 16);
        checks++;
        if (stable !== 1'b1 || idle_ok !== 1'b1) begin
            errors++;
            $display("FAIL backpressure_hold: stable=%0b idle=%0b required 1,1", stable, idle_ok);
        end
        checks++;
        if (f !== exp[15:0] || cout !== exp[16]) begin
            errors++;
            $display("FAIL backpressure_data: f=%h cout=%0b required %h,%0b",
                     f, cout, exp[15:0], exp[16]);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] a0, b0, a1, b1;
        logic [15:0] got_f[2];
        logic [17:0] exp0, exp1;
        int          acc_cyc[2];
        int          rsp_cyc[2];
        int          acc_n, rsp_n, overlap;
        a0 = 16'($urandom); b0 = 16'($urandom); a1 = 16'($urandom); b1 = 16'($urandom);
        acc_n = 0; rsp_n = 0; overlap = 0;
        acc_cyc[0] = -1; acc_cyc[1] = -1; rsp_cyc[0] = -1; rsp_cyc[1] = -1;
        got_f[0] = '0; got_f[1] = '0;
        req_a = a0; req_b = b0; req_s = 4'b1001; req_m = 1'b0; req_cin = 1'b0;
        req_valid = 1'b1;
        rsp_ready = 1'b1;
        for (int c = 0; c < 40 && rsp_n < 2; c++) begin
            if (rsp_valid && req_ready) overlap++;
            if (rsp_valid) begin
                rsp_cyc[rsp_n] = c;
                got_f[rsp_n] = rsp_f;
                rsp_n++;
            end
            if (req_valid && req_ready) begin
                acc_cyc[acc_n] = c;
                acc_n++;
            end
            @(posedge clk);
            #1;
            if (acc_n == 1) begin
                req_a = a1; req_b = b1;
            end else if (acc_n == 2) begin
                req_valid = 1'b0;
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        exp0 = alu_model(a0, b0, 4'b1001, 1'b0, 1'b0, 16);
        exp1 = alu_model(a1, b1, 4'b1001, 1'b0, 1'b0, 16);
        checks++;
        if (rsp_n != 2 || got_f[0] !== exp0[15:0] || got_f[1] !== exp1[15:0]) begin
            errors++;
            $display("FAIL b2b_data: n=%0d f0=%h f1=%h required 2,%h,%h",
                     rsp_n, got_f[0], got_f[1], exp0[15:0], exp1[15:0]);
        end
        checks++;
        if (acc_n != 2 || acc_cyc[1] - acc_cyc[0] != NIB + 2 || acc_cyc[1] != rsp_cyc[0] + 1 ||
            overlap != 0) begin
            errors++;
            $display("FAIL b2b_timing: accepts=%0d interval=%0d rsp0=%0d acc1=%0d overlap=%0d required 2,%0d,acc1=rsp0+1,0",
                     acc_n, acc_cyc[1] - acc_cyc[0], rsp_cyc[0], acc_cyc[1], overlap, NIB + 2);
        end
    endtask

    task automatic test_reset_abort();
        logic [15:0] f, alua;
        logic        cout, aeqb, zero, stable, idle_ok;
        logic [7:0]  cins;
        int          lat, n, spurious;
        req_a = 16'h1234; req_b = 16'h1111; req_s = 4'b1001; req_m = 1'b0; req_cin = 1'b0;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || rsp_f !== 16'h0 || rsp_cout !== 1'b0 || rsp_aeqb !== 1'b0 ||
            rsp_zero !== 1'b0 || {alu_a, alu_b, alu_s, alu_m, alu_cin} !== 14'b00000000000010)
        begin
            errors++;
            $display("FAIL abort_reset_vals: valid=%0b f=%h cout=%0b aeqb=%0b zero=%0b alu=%b",
                     rsp_valid, rsp_f, rsp_cout, rsp_aeqb, rsp_zero,
                     {alu_a, alu_b, alu_s, alu_m, alu_cin});
        end
        @(negedge clk);
        rst_n = 1'b1;
        spurious = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp_valid || !req_ready) spurious++;
        end
        checks++;
        if (spurious != 0) begin
            errors++;
            $display("FAIL abort_no_rsp: %0d cycles with rsp_valid or !req_ready, required 0",
                     spurious);
        end
        run_op(16'h1234, 16'h1111, 4'b1001, 1'b0, 1'b0, 0, f, cout, aeqb, zero, lat, cins,
               alua, stable, idle_ok);
        checks++;
        if (f !== 16'h2345 || cout !== 1'b0 || lat !== NIB + 1) begin
            errors++;
            $display("FAIL abort_recover: f=%h cout=%0b lat=%0d required 2345,0,%0d",
                     f, cout, lat, NIB + 1);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random(40);
        test_backpressure();
        test_back_to_back();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
